// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute/writeback stage and its helpers.
package cpu_pkg;

    localparam int DATA_W = 8;  // operand/result width, matches register file word
    localparam int AW     = 3;  // register index width; R0 reads as zero

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W bits total.
// Bit 0 is folded in on the start edge, bits 1..DATA_W-1 on the following edges,
// so done is high in the cycle ending DATA_W edges after start.
module mul_iter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] prod_lo,
    output logic              hi_nz
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mult;
    logic [CNT_W-1:0]    cnt;
    logic                busy;

    // Shift-add datapath and iteration counter.
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            mult  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            acc   <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
            mcand <= {{(DATA_W-1){1'b0}}, a, 1'b0};
            mult  <= b >> 1;
            cnt   <= CNT_W'(DATA_W - 1);
            busy  <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                acc   <= acc + (mult[0] ? mcand : '0);
                mcand <= mcand << 1;
                mult  <= mult >> 1;
                cnt   <= cnt - 1'b1;
            end
        end
    end

    assign done    = busy && (cnt == '0);
    assign prod_lo = acc[DATA_W-1:0];
    assign hi_nz   = |acc[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/writeback stage: operand forwarding, single-cycle ALU, iterative
// multiply, and a one-cycle writeback register driving the register file.
module exec_wb_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        opcode,
    input  logic [AW-1:0]     rd,
    input  logic [AW-1:0]     rs1,
    input  logic [AW-1:0]     rs2,
    output logic [AW-1:0]     r_add1,
    output logic [AW-1:0]     r_add2,
    input  logic [DATA_W-1:0] r_data1,
    input  logic [DATA_W-1:0] r_data2,
    output logic              we,
    output logic [AW-1:0]     w_add,
    output logic [DATA_W-1:0] w_data,
    output logic              flag_z,
    output logic              flag_c
);

    state_t            state;
    op_t               op;
    logic              accept;
    logic              mul_start;
    logic              mul_done;
    logic              mul_hi_nz;
    logic [DATA_W-1:0] mul_lo;
    logic [AW-1:0]     mul_rd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              fin_valid;
    logic [AW-1:0]     fin_rd;
    logic [DATA_W-1:0] fin_res;
    logic              fin_c;

    assign op        = op_t'(opcode);
    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign r_add1    = rs1;
    assign r_add2    = rs2;

    // The in-flight WB value has not reached the register file yet, so bypass it.
    // R0 never matches because we is never raised for w_add == 0.
    assign op_a = (we && (w_add == rs1)) ? w_data : r_data1;
    assign op_b = (we && (w_add == rs2)) ? w_data : r_data2;

    // Single-cycle ALU; carry is borrow for SUB and zero for logic/shift ops.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value held (no latch).
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        unique case (op)
            OP_ADD: {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB: {alu_c, alu_res} = {1'b0, op_a} - {1'b0, op_b};
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: alu_res = op_a << op_b[2:0];
            OP_SHR: alu_res = op_a >> op_b[2:0];
            OP_MUL: alu_res = '0;
        endcase
    end

    mul_iter u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .prod_lo (mul_lo),
        .hi_nz   (mul_hi_nz)
    );

    // Select whichever instruction completes on this edge (never both at once,
    // since nothing is accepted while a multiply runs).
    always_comb begin
        fin_valid = 1'b0;
        fin_rd    = rd;
        fin_res   = alu_res;
        fin_c     = alu_c;
        if (state == ST_MUL) begin
            fin_valid = mul_done;
            fin_rd    = mul_rd;
            fin_res   = mul_lo;
            fin_c     = mul_hi_nz;
        end else if (accept && (op != OP_MUL)) begin
            fin_valid = 1'b1;
        end
    end

    // FSM: IDLE accepts, MUL waits for the multiplier and remembers rd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mul_rd <= '0;
        end else if (mul_start) begin
            state  <= ST_MUL;
            mul_rd <= rd;
        end else if ((state == ST_MUL) && mul_done) begin
            state  <= ST_IDLE;
        end
    end

    // WB register and flags: loaded for one cycle on completion; R0 writes are suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we     <= 1'b0;
            w_add  <= '0;
            w_data <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (fin_valid) begin
            we     <= (fin_rd != '0);
            w_add  <= fin_rd;
            w_data <= fin_res;
            if (fin_rd != '0) begin
                flag_z <= (fin_res == '0);
                flag_c <= fin_c;
            end
        end else begin
            we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_wb_stage.sv
// Testbench for exec_wb_stage: register file model plus an architectural
// reference model (register values and flags computed with plain arithmetic).
module tb_exec_wb_stage;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic [2:0] rd, rs1, rs2;
    logic [2:0] r_add1, r_add2;
    logic [7:0] r_data1, r_data2;
    logic       we;
    logic [2:0] w_add;
    logic [7:0] w_data;
    logic       flag_z, flag_c;

    // register file model owned by the bench
    logic [7:0] rf [8] = '{default: 8'h00};
    logic       poke_en  = 1'b0;
    logic [2:0] poke_idx = 3'd1;
    logic [7:0] poke_val = 8'h00;

    // architectural reference state
    int arch [8];
    int mz, mc;
    int tests, fails;

    exec_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .r_add1(r_add1), .r_add2(r_add2), .r_data1(r_data1), .r_data2(r_data2),
        .we(we), .w_add(w_add), .w_data(w_data), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    assign r_data1 = rf[r_add1];
    assign r_data2 = rf[r_add2];

    always @(posedge clk) begin
        if (we && (w_add != 3'd0)) rf[w_add] <= w_data;
        if (poke_en) rf[poke_idx] <= poke_val;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Load a register file entry directly (after any pending DUT write lands).
    task automatic poke(input logic [2:0] idx, input logic [7:0] val);
        @(posedge clk);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
        arch[idx] = int'(val);
    endtask

    // Expected result and carry from the architectural rules.
    task automatic model(input op_t o, input int a, input int b, output int res, output int c);
        int p;
        c = 0;
        case (o)
            OP_ADD: begin p = a + b; res = p % 256; c = (p > 255) ? 1 : 0; end
            OP_SUB: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: res = (a << (b % 8)) % 256;
            OP_SHR: res = a >> (b % 8);
            default: begin p = a * b; res = p % 256; c = (p > 255) ? 1 : 0; end
        endcase
    endtask

    // Issue one instruction at the next edge and check its writeback.
    task automatic do_instr(input op_t o, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
        int res, c;
        model(o, arch[s1], arch[s2], res, c);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = o;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        #1;
        check("in_ready_before_accept", 16'(in_ready), 16'd1);
        check("r_add1", 16'(r_add1), 16'(s1));
        check("r_add2", 16'(r_add2), 16'(s2));
        @(posedge clk);
        #1;
        if (o == OP_MUL) begin
            check("mul_we_at_accept", 16'(we), 16'd0);
            // junk instruction presented while busy must be ignored
            in_valid = 1'b1;
            opcode   = 3'($urandom_range(0, 6));
            rd       = 3'($urandom_range(1, 7));
            for (int k = 1; k < 8; k++) begin
                @(posedge clk);
                #1;
                check("mul_in_ready_low", 16'(in_ready), 16'd0);
                check("mul_we_low", 16'(we), 16'd0);
            end
            @(posedge clk);
            #1;
            check("mul_in_ready_back", 16'(in_ready), 16'd1);
        end
        in_valid = 1'b0;
        check("we", 16'(we), (d != 3'd0) ? 16'd1 : 16'd0);
        check("w_add", 16'(w_add), 16'(d));
        check("w_data", 16'(w_data), 16'(res));
        if (d != 3'd0) begin
            arch[d] = res;
            mz = (res == 0) ? 1 : 0;
            mc = c;
        end
        check("flag_z", 16'(flag_z), 16'(mz));
        check("flag_c", 16'(flag_c), 16'(mc));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mz = 0;
        mc = 0;
        for (int i = 0; i < 8; i++) arch[i] = 0;

        // reset with a valid instruction presented: nothing may be written
        rst_n    = 1'b0;
        in_valid = 1'b1;
        opcode   = OP_ADD;
        rd       = 3'd3;
        rs1      = 3'd1;
        rs2      = 3'd2;
        poke(3'd1, 8'd5);
        poke(3'd2, 8'd3);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", 16'(we), 16'd0);
        check("rst_w_add", 16'(w_add), 16'd0);
        check("rst_w_data", 16'(w_data), 16'd0);
        check("rst_flag_z", 16'(flag_z), 16'd0);
        check("rst_flag_c", 16'(flag_c), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_no_write", 16'(rf[3]), 16'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // ADD then dependent SUB (RAW distance 1 through forwarding)
        do_instr(OP_ADD, 3'd3, 3'd1, 3'd2);
        do_instr(OP_SUB, 3'd4, 3'd3, 3'd1);
        repeat (2) @(posedge clk);
        #1;
        check("r3_written", 16'(rf[3]), 16'd8);
        check("r4_written", 16'(rf[4]), 16'd3);

        // carry, zero and borrow
        poke(3'd5, 8'hFF);
        poke(3'd6, 8'h01);
        do_instr(OP_ADD, 3'd7, 3'd5, 3'd6);
        poke(3'd5, 8'h02);
        poke(3'd6, 8'h05);
        do_instr(OP_SUB, 3'd7, 3'd5, 3'd6);

        // writes to R0 are dropped, flags untouched, R0 reads back as zero
        do_instr(OP_XOR, 3'd0, 3'd1, 3'd1);
        do_instr(OP_OR,  3'd0, 3'd1, 3'd2);
        do_instr(OP_ADD, 3'd4, 3'd0, 3'd1);

        // multiply with nonzero high half, followed by a dependent ADD at T+9
        poke(3'd1, 8'h13);
        poke(3'd2, 8'h0E);
        do_instr(OP_MUL, 3'd3, 3'd1, 3'd2);
        do_instr(OP_ADD, 3'd4, 3'd3, 3'd1);

        // reset in the middle of a multiply aborts it
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = OP_MUL;
        rd       = 3'd5;
        rs1      = 3'd1;
        rs2      = 3'd2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 16'(in_ready), 16'd1);
        check("abort_we", 16'(we), 16'd0);
        mz = 0;
        mc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_write", 16'(we), 16'd0);
        end
        check("abort_r5_kept", 16'(rf[5]), 16'(arch[5]));
        do_instr(OP_ADD, 3'd6, 3'd1, 3'd2);

        // randomized instruction stream against the architectural model
        for (int i = 1; i < 8; i++) poke(3'(i), 8'($urandom_range(0, 255)));
        for (int n = 0; n < 60; n++) begin
            do_instr(op_t'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) check("final_rf", 16'(rf[i]), 16'(arch[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
